fixedpoint_mac_pipe: RTL and testbench

//  Pipelined signed two's-complement fixed-point multiplier/accumulator with valid/ready flow control.

---
 rtl/fixedpoint_pkg.sv | 25 ++
 rtl/fixedpoint_sat.sv | 36 +++
 rtl/fixedpoint_mac_pipe.sv | 153 +++++++++++++++
 tb/tb_fixedpoint_mac_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixedpoint_pkg.sv
// Shared constants and the output scaling helper for the fixed-point MAC pipeline.
// Scaling is done in a wide signed domain so the half-up bias can never overflow.
package fixedpoint_pkg;

    localparam int   FXP_W      = 64;
    localparam logic RND_TRUNC  = 1'b0;
    localparam logic RND_HALFUP = 1'b1;
    localparam logic MODE_MUL   = 1'b0;
    localparam logic MODE_ACC   = 1'b1;

    function automatic logic signed [FXP_W-1:0] fxp_scale(
        input logic signed [FXP_W-1:0] v,
        input int                      sh,
        input logic                    rnd
    );
        logic signed [FXP_W-1:0] bias;
        if ((rnd == RND_HALFUP) && (sh > 32'sd0)) begin
            bias = 64'sd1 <<< (sh - 32'sd1);
        end else begin
            bias = {FXP_W{1'b0}};
        end
        return (v + bias) >>> sh;
    endfunction

endpackage

// File: rtl/fixedpoint_sat.sv
// Range check of a scaled result against OUT_W and final output formatting.
// Build option FXP_SAT_EN: clamp to the extreme code on overflow; otherwise the low bits wrap.
module fixedpoint_sat
    import fixedpoint_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic signed [FXP_W-1:0] q,
    output logic        [OUT_W-1:0] out,
    output logic                    ovf
);

    localparam logic signed [FXP_W-1:0] Q_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [FXP_W-1:0] Q_MIN = -(64'sd1 <<< (OUT_W - 1));
`ifdef FXP_SAT_EN
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    // Overflow detection and output selection.
    always_comb begin
        ovf = (q > Q_MAX) || (q < Q_MIN);
`ifdef FXP_SAT_EN
        if (!ovf) begin
            out = q[OUT_W-1:0];
        end else if (q[FXP_W-1]) begin
            out = SAT_NEG;
        end else begin
            out = SAT_POS;
        end
`else
        out = q[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/fixedpoint_mac_pipe.sv
// Three-stage signed fixed-point multiply/accumulate with valid/ready flow control.
// Build option FXP_SAT_EN (in fixedpoint_sat): saturate instead of wrap on overflow.
module fixedpoint_mac_pipe
    import fixedpoint_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 1,
    parameter int ACC_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic             in_mode,
    input  logic             in_clr,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_ovf
);

    localparam int P_W = 2 * IN_W;
    localparam int SH  = 2 * IN_FRAC - OUT_FRAC;

    logic                    adv_s;
    logic                    v1_q, v1_d, mode1_q, mode1_d, clr1_q, clr1_d, rnd1_q, rnd1_d;
    logic signed [IN_W-1:0]  a1_q, a1_d, b1_q, b1_d;
    logic                    v2_q, v2_d, mode2_q, mode2_d, clr2_q, clr2_d, rnd2_q, rnd2_d;
    logic signed [P_W-1:0]   p2_q, p2_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, p_ext_s, acc_new_s;
    logic signed [FXP_W-1:0] v_s, q_s;
    logic [OUT_W-1:0]        out_q, out_d, sat_out_s;
    logic                    ovf_q, ovf_d, sat_ovf_s, out_valid_q, out_valid_d;

    // A single advance strobe freezes the whole pipe, so beats cannot be lost or reordered.
    assign adv_s    = !out_valid_q || out_ready;
    assign in_ready = adv_s;

    // Third-stage datapath: widen the product, fold into the accumulator, pick source and scale.
    always_comb begin
        p_ext_s = ACC_W'(p2_q);
        if (clr2_q) begin
            acc_new_s = p_ext_s;
        end else begin
            acc_new_s = acc_q + p_ext_s;
        end
        if (mode2_q == MODE_ACC) begin
            v_s = FXP_W'(acc_new_s);
        end else begin
            v_s = FXP_W'(p_ext_s);
        end
        q_s = fxp_scale(v_s, SH, rnd2_q);
    end

    fixedpoint_sat #(.OUT_W(OUT_W)) u_sat (
        .q   (q_s),
        .out (sat_out_s),
        .ovf (sat_ovf_s)
    );

    // Next-state for all pipeline registers; everything holds while stalled.
    always_comb begin
        if (adv_s) begin
            v1_d        = in_valid;
            a1_d        = in1;
            b1_d        = in2;
            mode1_d     = in_mode;
            clr1_d      = in_clr;
            rnd1_d      = in_rnd;
            v2_d        = v1_q;
            p2_d        = P_W'(a1_q) * P_W'(b1_q);
            mode2_d     = mode1_q;
            clr2_d      = clr1_q;
            rnd2_d      = rnd1_q;
            out_valid_d = v2_q;
            if (v2_q) begin
                out_d = sat_out_s;
                ovf_d = sat_ovf_s;
            end else begin
                out_d = out_q;
                ovf_d = ovf_q;
            end
            if (v2_q && (mode2_q == MODE_ACC)) begin
                acc_d = acc_new_s;
            end else begin
                acc_d = acc_q;
            end
        end else begin
            v1_d        = v1_q;
            a1_d        = a1_q;
            b1_d        = b1_q;
            mode1_d     = mode1_q;
            clr1_d      = clr1_q;
            rnd1_d      = rnd1_q;
            v2_d        = v2_q;
            p2_d        = p2_q;
            mode2_d     = mode2_q;
            clr2_d      = clr2_q;
            rnd2_d      = rnd2_q;
            out_valid_d = out_valid_q;
            out_d       = out_q;
            ovf_d       = ovf_q;
            acc_d       = acc_q;
        end
    end

    // Pipeline state; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            a1_q        <= {IN_W{1'b0}};
            b1_q        <= {IN_W{1'b0}};
            mode1_q     <= 1'b0;
            clr1_q      <= 1'b0;
            rnd1_q      <= 1'b0;
            v2_q        <= 1'b0;
            p2_q        <= {P_W{1'b0}};
            mode2_q     <= 1'b0;
            clr2_q      <= 1'b0;
            rnd2_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= {OUT_W{1'b0}};
            ovf_q       <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            mode1_q     <= mode1_d;
            clr1_q      <= clr1_d;
            rnd1_q      <= rnd1_d;
            v2_q        <= v2_d;
            p2_q        <= p2_d;
            mode2_q     <= mode2_d;
            clr2_q      <= clr2_d;
            rnd2_q      <= rnd2_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fixedpoint_mac_pipe.sv
// Bench for fixedpoint_mac_pipe: directed cases plus randomized beats against an arithmetic model.
module tb_fixedpoint_mac_pipe;

    localparam int IN_W     = 8;
    localparam int IN_FRAC  = 4;
    localparam int OUT_W    = 8;
    localparam int OUT_FRAC = 1;
    localparam int ACC_W    = 20;
    localparam int SH       = 2 * IN_FRAC - OUT_FRAC;

    typedef struct {
        logic [OUT_W-1:0] o;
        logic             ovf;
        int               cyc;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in1 = 8'h00;
    logic [IN_W-1:0]  in2 = 8'h00;
    logic             in_mode = 1'b0;
    logic             in_clr = 1'b0;
    logic             in_rnd = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out;
    logic             out_ovf;

    int     n_chk = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    longint acc_m = 0;
    bit     rand_ready = 1'b0;
    res_t   exp_q[$];
    res_t   got_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fixedpoint_mac_pipe #(
        .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .in_mode(in_mode), .in_clr(in_clr), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(out_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: exact integer product, accumulator kept modulo 2^ACC_W, then divide by 2^SH.
    function automatic res_t model(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                   input logic mode, input logic clr, input logic rnd);
        longint p, v, q, m, lim;
        res_t   r;
        p = longint'($signed(a)) * longint'($signed(b));
        m = longint'(1) << ACC_W;
        if (mode) begin
            acc_m = clr ? p : acc_m + p;
            acc_m = ((acc_m % m) + m) % m;
            if (acc_m >= m / 2) acc_m = acc_m - m;
        end
        v = mode ? acc_m : p;
        if (rnd && SH > 0) v = v + (longint'(1) << (SH - 1));
        q   = v >>> SH;
        lim = longint'(1) << (OUT_W - 1);
        r.ovf = (q > lim - 1) || (q < -lim);
`ifdef FXP_SAT_EN
        if (q > lim - 1)   q = lim - 1;
        else if (q < -lim) q = -lim;
`endif
        r.o   = q[OUT_W-1:0];
        r.cyc = 0;
        return r;
    endfunction

    // Monitor at the falling edge: score transfers and enqueue expectations for accepted beats.
    initial begin
        res_t r, e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    r.o = out; r.ovf = out_ovf; r.cyc = cyc;
                    got_q.push_back(r);
                    if (exp_q.size() == 0) begin
                        check_val("spurious_out", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("sb_out", 32'(out), 32'(e.o));
                        check_val("sb_ovf", 32'(out_ovf), 32'(e.ovf));
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(in1, in2, in_mode, in_clr, in_rnd));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Called just after a rising edge; holds the beat until it is accepted.
    task automatic beat(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                        input logic mode, input logic clr, input logic rnd);
        int   t;
        logic ok;
        t = 0; ok = 1'b0;
        in1 = a; in2 = b; in_mode = mode; in_clr = clr; in_rnd = rnd; in_valid = 1'b1;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            acc_cyc = cyc;
            @(posedge clk); #1;
            t++;
        end
        check_val("beat_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 200) begin
            idle(1);
            t++;
        end
        check_val("result_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out", 32'(out), 32'd0);
        check_val("rst_ovf", 32'(out_ovf), 32'd0);
        exp_q.delete(); got_q.delete(); acc_m = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [OUT_W-1:0] held;
        int               a0;

        do_reset();

        // 1: back-to-back multiplies, floor rounding, latency and spacing
        got_q.delete();
        beat(8'hf0, 8'hf0, 1'b0, 1'b0, 1'b0);
        a0 = acc_cyc;
        beat(8'he8, 8'h30, 1'b0, 1'b0, 1'b0);
        beat(8'hec, 8'h30, 1'b0, 1'b0, 1'b0);
        wait_got(3);
        if (got_q.size() == 3) begin
            check_val("t1_out0", 32'(got_q[0].o), 32'h02);
            check_val("t1_out1", 32'(got_q[1].o), 32'hf7);
            check_val("t1_out2", 32'(got_q[2].o), 32'hf8);
            check_val("t1_ovf", 32'({got_q[0].ovf, got_q[1].ovf, got_q[2].ovf}), 32'd0);
            check_val("t1_latency", 32'(got_q[0].cyc - a0), 32'd3);
            check_val("t1_spacing", 32'(got_q[2].cyc - got_q[0].cyc), 32'd2);
        end

        // 2: round half up
        got_q.delete();
        beat(8'hec, 8'h30, 1'b0, 1'b0, 1'b1);
        beat(8'he8, 8'h30, 1'b0, 1'b0, 1'b1);
        wait_got(2);
        if (got_q.size() == 2) begin
            check_val("t2_rnd_a", 32'(got_q[0].o), 32'hf9);
            check_val("t2_rnd_b", 32'(got_q[1].o), 32'hf7);
        end

        // 3: accumulate with clear on first and on a later beat
        got_q.delete();
        for (int i = 0; i < 5; i++) beat(8'h10, 8'h10, 1'b1, (i == 0 || i == 4), 1'b0);
        wait_got(5);
        if (got_q.size() == 5) begin
            check_val("t3_acc1", 32'(got_q[0].o), 32'h02);
            check_val("t3_acc2", 32'(got_q[1].o), 32'h04);
            check_val("t3_acc3", 32'(got_q[2].o), 32'h06);
            check_val("t3_acc4", 32'(got_q[3].o), 32'h08);
            check_val("t3_clr", 32'(got_q[4].o), 32'h02);
        end

        // 4: accumulator overflow of the output range
        got_q.delete();
        beat(8'h7f, 8'h7f, 1'b1, 1'b1, 1'b0);
        beat(8'h7f, 8'h7f, 1'b1, 1'b0, 1'b0);
        wait_got(2);
        if (got_q.size() == 2) begin
            check_val("t4_out0", 32'(got_q[0].o), 32'h7e);
            check_val("t4_ovf0", 32'(got_q[0].ovf), 32'd0);
`ifdef FXP_SAT_EN
            check_val("t4_out1", 32'(got_q[1].o), 32'h7f);
`else
            check_val("t4_out1", 32'(got_q[1].o), 32'hfc);
`endif
            check_val("t4_ovf1", 32'(got_q[1].ovf), 32'd1);
        end

        // 5: downstream stall freezes the pipe
        got_q.delete();
        beat(8'h20, 8'h10, 1'b0, 1'b0, 1'b0);
        beat(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        beat(8'hec, 8'h30, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        held = out;
        for (int i = 0; i < 5; i++) begin
            check_val("t5_in_ready", 32'(in_ready), 32'd0);
            check_val("t5_valid", 32'(out_valid), 32'd1);
            check_val("t5_hold", 32'(out), 32'(held));
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_got(3);
        if (got_q.size() == 3) begin
            check_val("t5_order0", 32'(got_q[0].o), 32'h04);
            check_val("t5_order1", 32'(got_q[1].o), 32'h02);
            check_val("t5_order2", 32'(got_q[2].o), 32'hf8);
        end

        // 6: reset mid-stream flushes beats and accumulator
        beat(8'h7f, 8'h7f, 1'b1, 1'b1, 1'b0);
        beat(8'h7f, 8'h7f, 1'b1, 1'b0, 1'b0);
        do_reset();
        beat(8'h10, 8'h10, 1'b1, 1'b0, 1'b0);
        wait_got(1);
        idle(6);
        check_val("t6_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check_val("t6_out", 32'(got_q[0].o), 32'h02);

        // Randomized beats with random idles and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            beat(IN_W'($urandom), IN_W'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int t = 0; t < 500 && exp_q.size() > 0; t++) idle(1);
        check_val("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
